// File: rtl/fsm_moore_timed.sv
// ----------------------------------------------------------------------------
// fsm_moore_timed
//
// Timed Moore detector for a slow, already-synchronous input. A prescaler
// makes a sample tick every DIV enabled clocks. The FSM needs N consecutive
// high samples of X to enter FIRE. It holds Q for HOLD ticks, then waits in
// REARM until X goes low. This stops a held input from retriggering.
// Entries into FIRE are counted in a saturating counter.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous active-low reset
//   EN     in   1   run enable for prescaler and FSM
//   X      in   1   sampled input (synchronous to clk)
//   Q      out  1   high only in state FIRE
//   START  out  1   one-clk pulse, registered copy of the sample tick
//   BUSY   out  1   high whenever state != IDLE
//   COUNT  out  CW  saturating count of entries into FIRE
// ----------------------------------------------------------------------------
module fsm_moore_timed #(
    parameter int DIV  = 50,
    parameter int N    = 1,
    parameter int HOLD = 1,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          EN,
    input  logic          X,
    output logic          Q,
    output logic          START,
    output logic          BUSY,
    output logic [CW-1:0] COUNT
);

    localparam int PW = (DIV  > 1) ? $clog2(DIV)  : 1;
    localparam int RW = $clog2(N + 1);   // run must be able to hold N
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_FIRE  = 2'd2,
        S_REARM = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_pre;
    logic [RW-1:0]   r_run,   w_run_nxt;
    logic [HW-1:0]   r_hold,  w_hold_nxt;
    logic [CW-1:0]   r_count;
    logic            r_start;
    logic            w_tick;
    logic            w_cnt_inc;

    assign w_tick = EN && (r_pre == PW'(DIV - 1));

    // Prescaler and START pulse. START lines up with the cycle in which the
    // tick's state update becomes visible.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre   <= '0;
            r_start <= 1'b0;
        end else begin
            r_start <= w_tick;
            if (!EN || w_tick) r_pre <= '0;
            else               r_pre <= r_pre + 1'b1;
        end
    end

    // State, run/hold counters and detection counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_run   <= '0;
            r_hold  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_hold  <= w_hold_nxt;
            if (w_cnt_inc && (r_count != '1)) r_count <= r_count + 1'b1;
        end
    end

    // Next-state logic. It moves only on a tick; otherwise everything holds,
    // and that also covers the EN=0 freeze.
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned (which would infer a latch).
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_hold_nxt  = r_hold;
        w_cnt_inc   = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (X) begin
                        if (N == 1) begin
                            w_state_nxt = S_FIRE;
                            w_hold_nxt  = '0;
                            w_cnt_inc   = 1'b1;
                        end else begin
                            w_state_nxt = S_ARM;
                            w_run_nxt   = RW'(1);
                        end
                    end
                end
                S_ARM: begin
                    if (!X) begin
                        w_state_nxt = S_IDLE;
                        w_run_nxt   = '0;
                    end else if ((r_run + 1'b1) == RW'(N)) begin
                        w_state_nxt = S_FIRE;
                        w_run_nxt   = '0;
                        w_hold_nxt  = '0;
                        w_cnt_inc   = 1'b1;
                    end else begin
                        w_run_nxt   = r_run + 1'b1;
                    end
                end
                S_FIRE: begin
                    // X is deliberately ignored while firing.
                    if (r_hold == HW'(HOLD - 1)) w_state_nxt = S_REARM;
                    else                         w_hold_nxt  = r_hold + 1'b1;
                end
                S_REARM: begin
                    if (!X) begin
                        w_state_nxt = S_IDLE;
                        w_run_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    // Moore outputs: decoded from the state register only.
    assign Q     = (r_state == S_FIRE);
    assign BUSY  = (r_state != S_IDLE);
    assign START = r_start;
    assign COUNT = r_count;

endmodule

// File: tb/tb_fsm_moore_timed.sv
// ----------------------------------------------------------------------------
// tb_fsm_moore_timed
//
// Directed bench. The main DUT uses DIV=4, N=3, HOLD=2, CW=4. A second DUT
// uses the legacy configuration DIV=1, N=1, HOLD=1. Inputs change and outputs
// are sampled 1 time unit after each rising edge. Expected values are worked
// out by hand from the tick schedule.
// ----------------------------------------------------------------------------
module tb_fsm_moore_timed;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, x;
    logic       q, start, busy;
    logic [3:0] count;
    logic       en2, x2;
    logic       q2, start2, busy2;
    logic [3:0] count2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fsm_moore_timed #(.DIV(4), .N(3), .HOLD(2), .CW(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .EN    (en),
        .X     (x),
        .Q     (q),
        .START (start),
        .BUSY  (busy),
        .COUNT (count)
    );

    fsm_moore_timed #(.DIV(1), .N(1), .HOLD(1), .CW(4)) dut_legacy (
        .clk   (clk),
        .reset (rst_n),
        .EN    (en2),
        .X     (x2),
        .Q     (q2),
        .START (start2),
        .BUSY  (busy2),
        .COUNT (count2)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full detect/release cycle for the main DUT. It must start just
    // after a tick edge with the FSM in IDLE.
    task automatic detect_cycle(input int idx);
        x = 1'b1;
        step(12);                       // ticks 1..3 -> FIRE
        check($sformatf("sat_q_hi_%0d", idx), q, 1'b1);
        step(8);                        // ticks 4..5 -> REARM
        x = 1'b0;
        step(4);                        // tick 6 -> IDLE
        check($sformatf("sat_busy_lo_%0d", idx), busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        x     = 1'b1;
        en2   = 1'b0;
        x2    = 1'b0;

        // ---- 1. Reset held with EN=1, X=1 ----
        step(3);
        check("rst_q",      q,      1'b0);
        check("rst_start",  start,  1'b0);
        check("rst_busy",   busy,   1'b0);
        check("rst_count",  count,  4'd0);
        check("rst_q2",     q2,     1'b0);
        check("rst_count2", count2, 4'd0);
        rst_n = 1'b1;

        // ---- 1/2. First START after 4 edges; detection with X held ----
        step(3);
        check("start_before_first", start, 1'b0);
        step(1);                                    // tick1: IDLE -> ARM
        check("start_first", start, 1'b1);
        check("t1_busy",     busy,  1'b1);
        check("t1_q",        q,     1'b0);
        step(1);
        check("start_width", start, 1'b0);
        step(3);                                    // tick2: run=2
        check("start_period", start, 1'b1);
        check("t2_q",         q,     1'b0);
        step(4);                                    // tick3: FIRE
        check("t3_q",     q,     1'b1);
        check("t3_count", count, 4'd1);
        step(4);                                    // tick4: hold=1
        check("t4_q", q, 1'b1);
        step(3);                                    // 8th clk of Q high
        check("q_8th_clk", q, 1'b1);
        step(1);                                    // tick5: REARM
        check("t5_q",    q,    1'b0);
        check("t5_busy", busy, 1'b1);
        step(4);                                    // tick6: REARM holds
        check("t6_busy", busy, 1'b1);
        check("t6_q",    q,    1'b0);
        x = 1'b0;
        step(4);                                    // tick7: IDLE
        check("t7_busy",  busy,  1'b0);
        check("t7_count", count, 4'd1);

        // ---- 3. Broken run X=1,1,0,1 ----
        x = 1'b1; step(4);
        check("br1_busy", busy, 1'b1);
        step(4);
        check("br2_busy", busy, 1'b1);
        check("br2_q",    q,    1'b0);
        x = 1'b0; step(4);
        check("br3_busy", busy, 1'b0);
        x = 1'b1; step(4);
        check("br4_busy", busy, 1'b1);
        check("br4_q",    q,    1'b0);
        x = 1'b0; step(4);                          // back to IDLE
        check("br_count", count, 4'd1);

        // ---- Mid-operation reset while in FIRE ----
        x = 1'b1;
        step(12);
        check("mid_q_before", q,     1'b1);
        check("mid_count",    count, 4'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_q",     q,     1'b0);
        check("mid_rst_busy",  busy,  1'b0);
        check("mid_rst_count", count, 4'd0);
        x = 1'b0;
        #1 rst_n = 1'b1;                            // prescaler restarts from 0

        // ---- 4. Saturation over 20 cycles ----
        for (int i = 1; i <= 20; i++) begin
            detect_cycle(i);
            check($sformatf("sat_count_%0d", i), count,
                  (i < 15) ? i : 15);
        end

        // ---- 5. Enable freeze in FIRE with hold=0 ----
        x = 1'b1;
        step(12);                                   // FIRE, hold=0
        check("frz_q_entry", q, 1'b1);
        step(1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check($sformatf("frz_start_%0d", i), start, 1'b0);
        end
        check("frz_q_held", q, 1'b1);
        en = 1'b1;
        step(3);
        check("frz_no_early_start", start, 1'b0);
        step(1);                                    // 1st tick after freeze
        check("frz_start_restart", start, 1'b1);
        check("frz_q_tick1",       q,     1'b1);
        step(4);                                    // 2nd tick -> REARM
        check("frz_q_fall", q,    1'b0);
        check("frz_busy",   busy, 1'b1);
        x = 1'b0;
        step(4);
        check("frz_idle",  busy,  1'b0);
        check("frz_count", count, 4'd15);

        // ---- 6. Legacy configuration ----
        en2 = 1'b1;
        x2  = 1'b1;
        step(1);                                    // IDLE -> FIRE
        check("leg_q_hi",   q2,     1'b1);
        check("leg_start",  start2, 1'b1);
        check("leg_count",  count2, 4'd1);
        step(1);                                    // FIRE -> REARM
        check("leg_q_lo",   q2,     1'b0);
        check("leg_busy",   busy2,  1'b1);
        step(3);
        check("leg_rearm_q",     q2,     1'b0);
        check("leg_rearm_busy",  busy2,  1'b1);
        check("leg_rearm_count", count2, 4'd1);
        x2 = 1'b0;
        step(1);
        check("leg_idle",  busy2,  1'b0);
        check("leg_count_final", count2, 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
